// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// ----------------------------------------------------------------------------
// Execute-stage multiply/divide unit. It holds the architectural HI/LO
// registers and models multi-cycle MULT/MULTU/DIV/DIVU latency with a
// countdown counter.
//
// The result is computed once, in the cycle the operation is accepted, and
// parked in pend_hi/pend_lo. It becomes architecturally visible in HI/LO
// only when the countdown expires. The hazard unit sees o_start/o_busy and
// stalls later HI/LO-touching instructions in D.
//
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   i_mdu_op   in   4   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, others none
//   i_mthilo   in   2   01 MTHI, 10 MTLO, 00/11 none
//   i_mfhilo   in   2   01 read HI, 10 read LO, 00/11 none
//   i_a        in  32   rs operand (forwarded)
//   i_b        in  32   rt operand (forwarded)
//   o_start    out  1   combinational, high when i_mdu_op is 1..4
//   o_busy     out  1   registered, high while an operation is in flight
//   o_hi       out 32   current HI register
//   o_lo       out 32   current LO register
//   o_mdu_out  out 32   combinational HI/LO read port selected by i_mfhilo
// ============================================================================
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  i_mdu_op,
   input  logic [1:0]  i_mthilo,
   input  logic [1:0]  i_mfhilo,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_start,
   output logic        o_busy,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic [31:0] o_mdu_out
);

   // The counter must be able to hold the longer of the two latencies.
   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MULT_LEN = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LEN  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;

   localparam logic [1:0] SEL_HI = 2'b01;
   localparam logic [1:0] SEL_LO = 2'b10;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CW-1:0] r_count;
   logic          r_busy;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_pend_hi;
   logic [31:0]   r_pend_lo;

   // ------------------------------------------------------------------------
   // Arithmetic datapath
   // ------------------------------------------------------------------------
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_squot;
   logic [31:0] w_srem;
   logic [31:0] w_uquot;
   logic [31:0] w_urem;
   logic        w_div_zero;
   logic        w_div_ovf;

   // Full-width products; operands are widened first so the multiply is 64-bit.
   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   assign w_div_zero = (i_b == 32'd0);

   // INT_MIN / -1 cannot be represented in 32 bits. The architecture wants
   // quotient INT_MIN and remainder 0, so that case is steered explicitly
   // rather than relying on the overflow behaviour of a signed divider.
   assign w_div_ovf = (i_a == INT_MIN) && (i_b == NEG_ONE);

   // Signed divide truncates toward zero; the remainder takes the dividend's sign.
   always_comb begin
      w_squot = 32'd0;
      w_srem  = 32'd0;
      if (w_div_zero) begin
         w_squot = 32'd0;
         w_srem  = 32'd0;
      end else if (w_div_ovf) begin
         w_squot = INT_MIN;
         w_srem  = 32'd0;
      end else begin
         w_squot = $signed(i_a) / $signed(i_b);
         w_srem  = $signed(i_a) % $signed(i_b);
      end
   end

   // Unsigned divide; a zero divisor is masked so no undefined value propagates.
   always_comb begin
      w_uquot = 32'd0;
      w_urem  = 32'd0;
      if (w_div_zero) begin
         w_uquot = 32'd0;
         w_urem  = 32'd0;
      end else begin
         w_uquot = i_a / i_b;
         w_urem  = i_a % i_b;
      end
   end

   // ------------------------------------------------------------------------
   // Operation decode: start strobe, latency and the result to park
   // ------------------------------------------------------------------------
   logic          w_start;
   logic [CW-1:0] w_len;
   logic [31:0]   w_res_hi;
   logic [31:0]   w_res_lo;

   // Decode the EX op; a divide by zero parks the current HI/LO so they survive.
   always_comb begin
      w_start  = 1'b0;
      w_len    = CNT_ZERO;
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (i_mdu_op)
         OP_MULT: begin
            w_start  = 1'b1;
            w_len    = MULT_LEN;
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         OP_MULTU: begin
            w_start  = 1'b1;
            w_len    = MULT_LEN;
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         OP_DIV: begin
            w_start = 1'b1;
            w_len   = DIV_LEN;
            if (w_div_zero) begin
               w_res_hi = r_hi;
               w_res_lo = r_lo;
            end else begin
               w_res_hi = w_srem;
               w_res_lo = w_squot;
            end
         end
         OP_DIVU: begin
            w_start = 1'b1;
            w_len   = DIV_LEN;
            if (w_div_zero) begin
               w_res_hi = r_hi;
               w_res_lo = r_lo;
            end else begin
               w_res_hi = w_urem;
               w_res_lo = w_uquot;
            end
         end
         default: begin
            w_start  = 1'b0;
            w_len    = CNT_ZERO;
            w_res_hi = r_hi;
            w_res_lo = r_lo;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control: accept, countdown, retire, moves
   // ------------------------------------------------------------------------
   logic          w_idle;
   logic          w_accept;
   logic          w_retire;
   logic          w_move_ok;
   logic [CW-1:0] w_count_nxt;

   assign w_idle    = (r_count == CNT_ZERO);
   assign w_accept  = w_idle && w_start;
   assign w_retire  = (r_count == CNT_ONE);
   // A move only lands when the unit is idle and no op is launching this cycle.
   assign w_move_ok = w_idle && !w_start;

   // Next counter value: load on accept, otherwise count down to zero.
   always_comb begin
      w_count_nxt = r_count;
      if (w_idle) begin
         if (w_start) begin
            w_count_nxt = w_len;
         end else begin
            w_count_nxt = CNT_ZERO;
         end
      end else begin
         // Reaching zero from one is the retire edge.
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   // Counter and busy flag; busy is the registered image of count != 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= CNT_ZERO;
         r_busy  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_busy  <= (w_count_nxt != CNT_ZERO);
      end
   end

   // Pending result capture; only an accepted op may overwrite it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
      end else if (w_accept) begin
         r_pend_hi <= w_res_hi;
         r_pend_lo <= w_res_lo;
      end
   end

   // Architectural HI/LO: written on retire, or by MTHI/MTLO when fully idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_retire) begin
         r_hi <= r_pend_hi;
         r_lo <= r_pend_lo;
      end else if (w_move_ok) begin
         case (i_mthilo)
            SEL_HI:  r_hi <= i_a;
            SEL_LO:  r_lo <= i_a;
            default: begin
               r_hi <= r_hi;
               r_lo <= r_lo;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_start = w_start;
   assign o_busy  = r_busy;
   assign o_hi    = r_hi;
   assign o_lo    = r_lo;

   // MFHI/MFLO read port; reads during busy see the old value by design.
   always_comb begin
      o_mdu_out = 32'd0;
      case (i_mfhilo)
         SEL_HI:  o_mdu_out = r_hi;
         SEL_LO:  o_mdu_out = r_lo;
         default: o_mdu_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit: each accepted op pushes its expected
// HI/LO and busy length; a monitor pops and compares when busy falls.
// ============================================================================
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic [3:0]  i_mdu_op;
   logic [1:0]  i_mthilo;
   logic [1:0]  i_mfhilo;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_start;
   logic        o_busy;
   logic [31:0] o_hi;
   logic [31:0] o_lo;
   logic [31:0] o_mdu_out;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;
   bit   abort = 1'b0;
   bit   prev_busy = 1'b0;
   int   busy_cnt = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_mdu_op  (i_mdu_op),
      .i_mthilo  (i_mthilo),
      .i_mfhilo  (i_mfhilo),
      .i_a       (i_a),
      .i_b       (i_b),
      .o_start   (o_start),
      .o_busy    (o_busy),
      .o_hi      (o_hi),
      .o_lo      (o_lo),
      .o_mdu_out (o_mdu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Monitor: count busy cycles, compare against the scoreboard when busy drops.
   always @(negedge clk) begin
      if (o_busy === 1'b1) begin
         busy_cnt++;
      end else if (prev_busy) begin
         if (abort) begin
            abort = 1'b0;
         end else if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("busy_len", busy_cnt, e.len);
            chk("hi", o_hi, e.hi);
            chk("lo", o_lo, e.lo);
         end
         busy_cnt = 0;
      end
      prev_busy = (o_busy === 1'b1);
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                        input bit push, input logic [31:0] eh, input logic [31:0] el,
                        input int len);
      exp_t e;
      @(negedge clk);
      i_mdu_op = op;
      i_a      = ia;
      i_b      = ib;
      #1;
      chk("start", o_start, 1'b1);
      if (push) begin
         e.hi = eh;
         e.lo = el;
         e.len = len;
         sb.push_back(e);
      end
      @(negedge clk);
      i_mdu_op = OP_NONE;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_busy === 1'b0) break;
      end
      if (i >= 60) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      longint      p;
      logic [63:0] pu;

      reset    = 1'b1;
      i_mdu_op = OP_NONE;
      i_mthilo = 2'b00;
      i_mfhilo = 2'b00;
      i_a      = 32'd0;
      i_b      = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and read port
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_hi", o_hi, 32'd0);
      chk("rst_lo", o_lo, 32'd0);
      i_mfhilo = 2'b01; #1 chk("rst_mfhi", o_mdu_out, 32'd0);
      i_mfhilo = 2'b10; #1 chk("rst_mflo", o_mdu_out, 32'd0);
      i_mfhilo = 2'b00;
      i_mdu_op = 4'd5;  #1 chk("start_op5", o_start, 1'b0);
      i_mdu_op = OP_NONE; #1 chk("start_op0", o_start, 1'b0);

      // MULT / MULTU of -3 and 5
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      chk("hi_hidden_during_busy", o_hi, 32'd0);
      wait_idle();
      issue(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, 5);
      wait_idle();

      // Divides
      issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 10);
      wait_idle();
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_idle();
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 10);
      wait_idle();

      // MTHI while busy is dropped; MTLO while idle lands
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      repeat (2) @(negedge clk);
      i_mthilo = 2'b01; i_a = 32'h0000_1234;
      @(negedge clk);
      i_mthilo = 2'b00;
      wait_idle();
      @(negedge clk);
      i_mthilo = 2'b10; i_a = 32'h0000_ABCD;
      @(negedge clk);
      i_mthilo = 2'b00;
      chk("mtlo_lo", o_lo, 32'h0000_ABCD);
      chk("mtlo_hi_kept", o_hi, 32'hFFFF_FFFF);
      i_mfhilo = 2'b10; #1 chk("mflo", o_mdu_out, 32'h0000_ABCD);
      i_mfhilo = 2'b01; #1 chk("mfhi", o_mdu_out, 32'hFFFF_FFFF);
      i_mfhilo = 2'b11; #1 chk("mf11", o_mdu_out, 32'd0);
      i_mfhilo = 2'b00;

      // Second MULT one cycle after the first is ignored
      issue(OP_MULT, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 5);
      i_mdu_op = OP_MULT; i_a = 32'd7; i_b = 32'd7;
      @(negedge clk);
      i_mdu_op = OP_NONE;
      wait_idle();

      // start and MTLO together: op wins, move dropped
      @(negedge clk);
      i_mdu_op = OP_MULTU; i_a = 32'd2; i_b = 32'd3; i_mthilo = 2'b10;
      begin
         exp_t e;
         e.hi = 32'd0; e.lo = 32'd6; e.len = 5;
         sb.push_back(e);
      end
      @(negedge clk);
      i_mdu_op = OP_NONE; i_mthilo = 2'b00;
      chk("mtlo_dropped", o_lo, 32'd12);
      chk("busy_after_accept", o_busy, 1'b1);
      wait_idle();

      // mthilo == 11 does nothing
      @(negedge clk);
      i_mthilo = 2'b11; i_a = 32'h5555_5555;
      @(negedge clk);
      i_mthilo = 2'b00;
      chk("mt11_hi", o_hi, 32'd0);
      chk("mt11_lo", o_lo, 32'd6);

      // Reset in cycle 4 of a DIV abandons it
      abort = 1'b1;
      issue(OP_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", o_busy, 1'b0);
      chk("rst_mid_hi", o_hi, 32'd0);
      chk("rst_mid_lo", o_lo, 32'd0);
      repeat (15) @(negedge clk);
      chk("no_late_wb_hi", o_hi, 32'd0);
      chk("no_late_wb_lo", o_lo, 32'd0);
      chk("no_late_busy", o_busy, 1'b0);

      // Divide by zero keeps HI/LO
      @(negedge clk);
      i_mthilo = 2'b01; i_a = 32'd7;
      @(negedge clk);
      i_mthilo = 2'b10; i_a = 32'd9;
      @(negedge clk);
      i_mthilo = 2'b00;
      chk("pre_hi", o_hi, 32'd7);
      chk("pre_lo", o_lo, 32'd9);
      issue(OP_DIV, 32'd5, 32'd0, 1'b1, 32'd7, 32'd9, 10);
      wait_idle();
      issue(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'd7, 32'd9, 10);
      wait_idle();

      // Random signed multiplies and unsigned divides
      for (int k = 0; k < 3; k++) begin
         ra = $urandom;
         rb = $urandom;
         p  = longint'($signed(ra)) * longint'($signed(rb));
         issue(OP_MULT, ra, rb, 1'b1, p[63:32], p[31:0], 5);
         wait_idle();
         pu = {32'd0, ra} * {32'd0, rb};
         issue(OP_MULTU, ra, rb, 1'b1, pu[63:32], pu[31:0], 5);
         wait_idle();
         rb = $urandom_range(1, 100000);
         issue(OP_DIVU, ra, rb, 1'b1, ra % rb, ra / rb, 10);
         wait_idle();
      end

      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
